// File: rtl/spi_readout_frame_assembler.sv
// spi_readout_frame_assembler
// Takes the received SPI MISO byte stream, drops idle filler bytes, locates
// length-prefixed frame headers and re-emits each frame as an AXIS byte packet
// terminated by tlast. A frame that stalls too long, or is interrupted by
// enable=0, is closed with a filler byte carrying tlast plus an err_timeout pulse.
// Optional build macro: FRAME_ASSEMBLER_STATS_EN (implements frame_count).
//
// Handshake: a byte moves on either AXIS interface only on a clock edge where
// tvalid && tready are both high; a producer holding tvalid keeps tdata/tlast
// stable until that edge, and the output side never withdraws tvalid early.
module spi_readout_frame_assembler #(
  parameter logic [7:0] IDLE_BYTE   = 8'hBC,
  parameter int         MAX_LEN     = 15,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        err_len,
  output logic        err_timeout,
  output logic [15:0] frame_count,
  output logic [1:0]  dbg_state
);

  localparam int IC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CLOSE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [4:0]      r_remaining;
  logic [IC_W-1:0] r_idle_cnt;
  logic [7:0]      r_m_tdata;
  logic            r_m_tvalid;
  logic            r_m_tlast;
  logic            r_err_len;
  logic            r_err_timeout;

  state_t          w_state_nx;
  logic [4:0]      w_rem_nx;
  logic [IC_W-1:0] w_idle_nx;
  logic            w_load;
  logic [7:0]      w_ld_data;
  logic            w_ld_last;
  logic            w_err_len_nx;
  logic            w_err_to_nx;
  logic            w_tready;
  logic            w_out_free;
  logic            w_acc;
  logic            w_is_idle;
  logic [4:0]      w_len;
  logic            w_len_bad;

  assign w_out_free = !r_m_tvalid || m_axis_tready;
  assign w_is_idle  = (s_axis_tdata == IDLE_BYTE);
  assign w_len      = s_axis_tdata[4:0];
  assign w_len_bad  = (w_len == 5'd0) || (w_len > 5'(MAX_LEN));

  // Input ready: filler bytes in IDLE are swallowed even when the output is stalled
  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      S_IDLE:    w_tready = enable && (w_out_free || (s_axis_tvalid && w_is_idle));
      S_PAYLOAD: w_tready = enable && w_out_free;
      default:   w_tready = 1'b0;
    endcase
  end

  assign s_axis_tready = !rst && w_tready;
  assign w_acc         = s_axis_tvalid && s_axis_tready;

  // Next-state, counters and output-slot load decisions
  always_comb begin
    w_state_nx   = r_state;
    w_rem_nx     = r_remaining;
    w_idle_nx    = r_idle_cnt;
    w_load       = 1'b0;
    w_ld_data    = r_m_tdata;
    w_ld_last    = 1'b0;
    w_err_len_nx = 1'b0;
    w_err_to_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !w_is_idle) begin
          if (w_len_bad) begin
            w_err_len_nx = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_ld_data  = s_axis_tdata;
            w_rem_nx   = w_len;
            w_idle_nx  = '0;
            w_state_nx = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        // An accepted byte beats a timeout expiring on the same cycle
        if (w_acc) begin
          w_load    = 1'b1;
          w_ld_data = s_axis_tdata;
          w_idle_nx = '0;
          w_rem_nx  = r_remaining - 5'd1;
          if (r_remaining == 5'd1) begin
            w_ld_last  = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else if (!enable || (r_idle_cnt == IC_W'(TIMEOUT_CYC - 1))) begin
          w_state_nx = S_CLOSE;
        end else begin
          w_idle_nx = r_idle_cnt + IC_W'(1);
        end
      end
      S_CLOSE: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_ld_data   = IDLE_BYTE;
          w_ld_last   = 1'b1;
          w_err_to_nx = 1'b1;
          w_idle_nx   = '0;
          w_rem_nx    = 5'd0;
          w_state_nx  = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM state, counters and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_remaining   <= 5'd0;
      r_idle_cnt    <= '0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_remaining   <= w_rem_nx;
      r_idle_cnt    <= w_idle_nx;
      r_err_len     <= w_err_len_nx;
      r_err_timeout <= w_err_to_nx;
    end
  end

  // Single output register stage; a load only happens when the slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= 8'h00;
      r_m_tlast  <= 1'b0;
    end else if (w_load) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_ld_data;
      r_m_tlast  <= w_ld_last;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef FRAME_ASSEMBLER_STATS_EN
  logic        w_frame_done;
  logic [15:0] r_frame_count;

  assign w_frame_done = (r_state == S_PAYLOAD) && w_acc && (r_remaining == 5'd1);

  // Count normally completed frames; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= 16'h0000;
    end else if (w_frame_done) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'h0000;
`endif

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign err_len       = r_err_len;
  assign err_timeout   = r_err_timeout;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_spi_readout_frame_assembler.sv
// Bench for spi_readout_frame_assembler: directed frames, expected output bytes
// queued by the stimulus side and checked by an independent output monitor.
module tb_spi_readout_frame_assembler;

`ifdef FRAME_ASSEMBLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        err_len;
  logic        err_timeout;
  logic [15:0] frame_count;
  logic [1:0]  dbg_state;

  logic [8:0]  exp_q[$];
  int          n_vec;
  int          n_err;
  int          n_err_len;
  int          n_err_to;
  bit          toggle_en;
  bit          hold_v;
  logic [8:0]  held;

  spi_readout_frame_assembler dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .err_len       (err_len),
    .err_timeout   (err_timeout),
    .frame_count   (frame_count),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_fc(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  // Downstream ready toggler for the stall test
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_tready = ~m_tready;
    end
  end

  // Monitor: pops the expected queue on every output handshake, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (err_len) n_err_len++;
      if (err_timeout) n_err_to++;
      if (hold_v) begin
        chk("stall_valid", 16'(m_tvalid), 16'h1);
        chk("stall_data", 16'({m_tlast, m_tdata}), 16'(held));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %h, expected no output", {m_tlast, m_tdata});
        end else begin
          chk("out_byte", 16'({m_tlast, m_tdata}), 16'(exp_q.pop_front()));
        end
      end
      hold_v = m_tvalid && !m_tready;
      held   = {m_tlast, m_tdata};
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    int   k;
    logic acc;
    s_tvalid = 1'b1;
    s_tdata  = b;
    k = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 200);
    chk("send_accept", 16'(acc), 16'h1);
    s_tvalid = 1'b0;
  endtask

  task automatic push(input logic last, input logic [7:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 16'(exp_q.size()), 16'h0);
  endtask

  task automatic wait_timeouts(input int n);
    int k;
    k = 0;
    while (n_err_to < n && k < 1500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("timeout_pulses", 16'(n_err_to), 16'(n));
  endtask

  // Main stimulus
  initial begin
    n_vec = 0; n_err = 0; n_err_len = 0; n_err_to = 0;
    toggle_en = 1'b0; hold_v = 1'b0; held = '0;
    rst = 1'b1; enable = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 16'(m_tvalid), 16'h0);
    chk("rst_tlast", 16'(m_tlast), 16'h0);
    chk("rst_tdata", 16'(m_tdata), 16'h0);
    chk("rst_s_tready", 16'(s_tready), 16'h0);
    chk("rst_errs", 16'({err_len, err_timeout}), 16'h0);
    chk("rst_frame_count", frame_count, 16'h0);
    chk("rst_state", 16'(dbg_state), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Filler stripped, one 3-byte frame
    push(0, 8'h03); push(0, 8'h11); push(0, 8'h22); push(1, 8'h33);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'hBC);
    drain();
    chk("fc_after_frame1", frame_count, exp_fc(1));

    // Illegal lengths 0 and 31
    send_byte(8'h00); send_byte(8'h1F);
    drain();
    chk("err_len_pulses", 16'(n_err_len), 16'h2);

    // Timeout closes a frame with a filler byte
    push(0, 8'h02); push(0, 8'hAA); push(1, 8'hBC);
    send_byte(8'h02); send_byte(8'hAA);
    wait_timeouts(1);
    drain();
    chk("fc_after_timeout", frame_count, exp_fc(1));

    // Output stall with ready toggling; BC is legal payload
    toggle_en = 1'b1;
    push(0, 8'h02); push(0, 8'hBC); push(1, 8'h55);
    send_byte(8'h02); send_byte(8'hBC); send_byte(8'h55);
    drain();
    toggle_en = 1'b0;
    m_tready = 1'b1;
    chk("fc_after_stall", frame_count, exp_fc(2));

    // Back-to-back single-byte frames
    push(0, 8'h01); push(1, 8'hAA); push(0, 8'h01); push(1, 8'hBB);
    send_byte(8'h01); send_byte(8'hAA); send_byte(8'h01); send_byte(8'hBB);
    drain();
    chk("fc_after_b2b", frame_count, exp_fc(4));

    // enable=0 mid-frame forces a close, then blocks input in IDLE
    push(0, 8'h03); push(0, 8'h11); push(1, 8'hBC);
    send_byte(8'h03); send_byte(8'h11);
    enable = 1'b0;
    wait_timeouts(2);
    drain();
    @(negedge clk);
    chk("disabled_s_tready", 16'(s_tready), 16'h0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    chk("fc_after_flush", frame_count, exp_fc(4));

    // Reset in the middle of a frame
    push(0, 8'h04); push(0, 8'h11);
    send_byte(8'h04); send_byte(8'h11);
    drain();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tvalid", 16'(m_tvalid), 16'h0);
    chk("mid_rst_tdata", 16'(m_tdata), 16'h0);
    chk("mid_rst_state", 16'(dbg_state), 16'h0);
    chk("mid_rst_fc", frame_count, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 8'h01); push(1, 8'hCC);
    send_byte(8'h01); send_byte(8'hCC);
    drain();
    chk("fc_after_rst_frame", frame_count, exp_fc(1));

    chk("err_len_total", 16'(n_err_len), 16'h2);
    chk("err_timeout_total", 16'(n_err_to), 16'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
